ring_alarm_ctrl: RTL and testbench
==================================

# ring_alarm_ctrl

Alarm ring sequencer for the clock/display design. It sits between the alarm-compare logic and the buzzer pin. On an alarm request it produces a gated square-wave tone on `clk_RING` in a fixed on/off beep pattern for a bounded number of beeps. The user can stop the ring at any time, and an optional snooze re-arms it.

## Interface
Parameters:
- `TONE_HALF`, 25000: cycles per tone half-period (1 kHz at 50 MHz `CLK_NX`); minimum 1.
- `BEEP_CYC`, 12500000: cycles per beep-on window and per beep-off window (250 ms); minimum 2.
- `BEEPS`, 60: number of on/off beep pairs per ring session; minimum 1.
- `SNOOZE_PERIODS`, 600: beep-pair periods spent in snooze (`RING_SNOOZE_EN` only).

Ports:
- `CLK_NX`, input, 1: system clock; all logic on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `armed`, input, 1: alarm enabled (level).
- `alarm_hit`, input, 1: one-cycle ring request from the alarm comparator.
- `stop`, input, 1: debounced user stop (one-cycle pulse).
- `snooze`, input, 1: debounced snooze pulse (`RING_SNOOZE_EN` only).
- `clk_RING`, output, 1: gated tone to the buzzer.
- `ringing`, output, 1: high while a session is active (TONE_ON or TONE_OFF).
- `done`, output, 1: one-cycle pulse when a session completes all `BEEPS` naturally.

## Operation
- Outputs are registered. Reset value of every output is 0. On reset the FSM goes to IDLE and all counters go to 0.
- States: IDLE, TONE_ON, TONE_OFF, DONE; SNOOZE is added when the macro is defined.
- IDLE → TONE_ON: when `alarm_hit && armed && !stop`. The beep counter clears.
- TONE_ON → TONE_OFF: after exactly `BEEP_CYC` cycles in TONE_ON.
- TONE_OFF → TONE_ON: after `BEEP_CYC` cycles, if fewer than `BEEPS` pairs have completed. Otherwise TONE_OFF → DONE.
- DONE → IDLE: unconditionally after one cycle. `done` is high only in DONE.
- In TONE_ON, `clk_RING` is 1 for the first `TONE_HALF` cycles, then toggles every `TONE_HALF` cycles. The tone counter restarts on every TONE_ON entry. `clk_RING` is 0 in all other states.
- `stop` or `!armed` in TONE_ON/TONE_OFF → IDLE on the next edge, with no `done`. `stop` has priority over every other transition.
- `alarm_hit` while not in IDLE is ignored; a session is never restarted or extended.
- `alarm_hit` and `stop` in the same IDLE cycle: stay in IDLE.
- Counter widths are computed with `$clog2` of each parameter (+1). Counters saturate rather than wrap; terminal compare is `== N-1`.

## Timing
- `alarm_hit` sampled at edge k: at k+1, `ringing`=1 and `clk_RING`=1.
- Session length is exactly 2·`BEEP_CYC`·`BEEPS` cycles with `ringing`=1. `done`=1 in the following cycle, with `ringing`=0.
- `stop` sampled at edge k: at k+1, `ringing`=0 and `clk_RING`=0.
- A new `alarm_hit` is accepted in the cycle after DONE, or after a stop, once back in IDLE.

## Configuration
- `RING_SNOOZE_EN` defined: adds the `snooze` port and the SNOOZE state.
  - `snooze` in TONE_ON/TONE_OFF → SNOOZE. `ringing` and `clk_RING` drop to 0.
  - After `SNOOZE_PERIODS`·2·`BEEP_CYC` cycles, SNOOZE → TONE_ON with the beep counter cleared.
  - `stop` or `!armed` in SNOOZE → IDLE.
  - `snooze` and `stop` in the same cycle: `stop` wins.
- Not defined: no `snooze` port, no SNOOZE state; the `SNOOZE_PERIODS` parameter is present but unused.

## Structure
- Shared package `ring_pkg`: state enum `ring_state_t` (IDLE, TONE_ON, TONE_OFF, DONE, SNOOZE), default-parameter localparams, and a width helper function.
- One sub-module, `ring_tone_gen`:
  - Inputs: `CLK_NX`, `reset`, `en`, `restart`. Output: tone.
  - Contains the `TONE_HALF` counter and toggle flop.
- FSM, beep-window counter and beep-pair counter stay in `ring_alarm_ctrl`.

## Test plan
Bench parameters: `TONE_HALF`=4, `BEEP_CYC`=20, `BEEPS`=3, `SNOOZE_PERIODS`=2, period 20 ns.

- Full session: `armed`=1, `alarm_hit` pulse → `ringing` high for exactly 120 cycles; `clk_RING` is 1,1,1,1,0,0,0,0… in each 20-cycle on window and 0 in each off window; `done` is high for 1 cycle at cycle 121.
- Stop mid-beep: `stop` at cycle 7 of TONE_ON → next cycle `ringing`=0, `clk_RING`=0, and `done` never asserts.
- Disarm and collision:
  - `armed`=0 with `alarm_hit` → no response.
  - `alarm_hit` and `stop` in the same cycle → stays in IDLE.
  - `armed` dropped during TONE_OFF → IDLE next cycle.
- Re-trigger: extra `alarm_hit` pulses during a session leave the 120-cycle length unchanged; an `alarm_hit` in the cycle after `done` starts a new session.
- Reset mid-session: `reset` at cycle 50 → all outputs are 0 on the next edge; after reset releases, a fresh `alarm_hit` gives a full 120-cycle session.
- Snooze (`RING_SNOOZE_EN`): `snooze` at cycle 30 → outputs are 0 for 80 cycles, then `ringing` returns with a full 3-beep session; `stop` during snooze → stays in IDLE.

Source files
------------

// File: rtl/ring_pkg.sv
// ring_pkg: shared state encoding, default parameters and counter width helper for the ring sequencer.
package ring_pkg;

    typedef enum logic [2:0] {IDLE, TONE_ON, TONE_OFF, DONE, SNOOZE} ring_state_t;

    localparam int TONE_HALF_DEF      = 25000;
    localparam int BEEP_CYC_DEF       = 12500000;
    localparam int BEEPS_DEF          = 60;
    localparam int SNOOZE_PERIODS_DEF = 600;

    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/ring_alarm_ctrl_if.sv
// ring_alarm_ctrl_if: control/status bundle between the alarm logic and the ring sequencer.
// The snooze line exists only when RING_SNOOZE_EN is defined.
interface ring_alarm_ctrl_if;

    logic armed;
    logic alarm_hit;
    logic stop;
`ifdef RING_SNOOZE_EN
    logic snooze;
`endif
    logic clk_RING;
    logic ringing;
    logic done;

    modport master (
        output armed, alarm_hit, stop,
`ifdef RING_SNOOZE_EN
        output snooze,
`endif
        input  clk_RING, ringing, done
    );

    modport slave (
        input  armed, alarm_hit, stop,
`ifdef RING_SNOOZE_EN
        input  snooze,
`endif
        output clk_RING, ringing, done
    );

endinterface

// File: rtl/ring_tone_gen.sv
// ring_tone_gen: registered square-wave tone that starts high on restart and toggles every TONE_HALF cycles.
module ring_tone_gen
    import ring_pkg::*;
#(
    parameter int TONE_HALF = TONE_HALF_DEF
) (
    input  logic CLK_NX,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic tone
);

    localparam int TW = cnt_w(TONE_HALF);
    localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF - 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge CLK_NX) begin
        if (reset || !en) begin
            cnt  <= '0;
            tone <= 1'b0;
        end else if (restart) begin
            cnt  <= '0;
            tone <= 1'b1;
        end else if (cnt == TONE_LAST) begin
            cnt  <= '0;
            tone <= ~tone;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ring_alarm_ctrl.sv
// ring_alarm_ctrl: alarm ring sequencer producing a bounded beep pattern on clk_RING.
// Defining RING_SNOOZE_EN adds the snooze input and the SNOOZE state.
module ring_alarm_ctrl
    import ring_pkg::*;
#(
    parameter int TONE_HALF      = TONE_HALF_DEF,
    parameter int BEEP_CYC       = BEEP_CYC_DEF,
    parameter int BEEPS          = BEEPS_DEF,
    parameter int SNOOZE_PERIODS = SNOOZE_PERIODS_DEF
) (
    input logic              CLK_NX,
    input logic              reset,
    ring_alarm_ctrl_if.slave bus
);

    // The pair counter also counts beep windows while snoozing, so size it for both uses.
    localparam int PN = (2 * SNOOZE_PERIODS > BEEPS) ? 2 * SNOOZE_PERIODS : BEEPS;
    localparam int BW = cnt_w(BEEP_CYC);
    localparam int PW = cnt_w(PN);
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_CYC - 1);
    localparam logic [PW-1:0] PAIR_LAST = PW'(BEEPS - 1);
    localparam logic [PW-1:0] PAIR_MAX  = PW'(PN);

    ring_state_t   state, next;
    logic [BW-1:0] beep_cnt;
    logic [PW-1:0] pair_cnt;
    logic          kill, snz, win_end, in_win, pair_clr, pair_inc;
    logic          ringing_d, done_d, tone_en, tone_restart;

    assign kill    = bus.stop || !bus.armed;
    assign win_end = beep_cnt == BEEP_LAST;
    assign in_win  = state inside {TONE_ON, TONE_OFF, SNOOZE};
`ifdef RING_SNOOZE_EN
    localparam logic [PW-1:0] SNZ_LAST = PW'(2 * SNOOZE_PERIODS - 1);
    assign snz = bus.snooze;
`else
    assign snz = 1'b0;
`endif

    always_ff @(posedge CLK_NX) begin
        if (reset) begin
            state       <= IDLE;
            bus.ringing <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            state       <= next;
            bus.ringing <= ringing_d;
            bus.done    <= done_d;
        end
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:     next = (bus.alarm_hit && bus.armed && !bus.stop) ? TONE_ON : IDLE;
            TONE_ON:  next = kill ? IDLE : snz ? SNOOZE : win_end ? TONE_OFF : TONE_ON;
            TONE_OFF: next = kill ? IDLE : snz ? SNOOZE : !win_end ? TONE_OFF :
                             (pair_cnt == PAIR_LAST) ? DONE : TONE_ON;
            DONE:     next = IDLE;
`ifdef RING_SNOOZE_EN
            SNOOZE:   next = kill ? IDLE : (win_end && pair_cnt == SNZ_LAST) ? TONE_ON : SNOOZE;
`endif
            default:  next = IDLE;
        endcase
    end

    always_comb begin
        ringing_d    = next inside {TONE_ON, TONE_OFF};
        done_d       = next == DONE;
        tone_en      = next == TONE_ON;
        tone_restart = tone_en && state != TONE_ON;
    end

    // Pairs restart on a fresh session or snooze boundary; TONE_OFF -> TONE_ON counts a completed pair.
    assign pair_clr = next == IDLE ||
                      (next != state && (next == SNOOZE || (next == TONE_ON && state != TONE_OFF)));
    assign pair_inc = win_end && state inside {TONE_OFF, SNOOZE} && pair_cnt != PAIR_MAX;

    always_ff @(posedge CLK_NX) begin
        if (reset) begin
            beep_cnt <= '0;
            pair_cnt <= '0;
        end else begin
            beep_cnt <= (!in_win || next != state || win_end) ? '0 : beep_cnt + 1'b1;
            pair_cnt <= pair_clr ? '0 : pair_inc ? pair_cnt + 1'b1 : pair_cnt;
        end
    end

    ring_tone_gen #(.TONE_HALF(TONE_HALF)) u_tone (
        .CLK_NX  (CLK_NX),
        .reset   (reset),
        .en      (tone_en),
        .restart (tone_restart),
        .tone    (bus.clk_RING)
    );

endmodule

// File: tb/tb_ring_alarm_ctrl.sv
// tb_ring_alarm_ctrl: scoreboard bench comparing every cycle of ring outputs against a session-offset model.
module tb_ring_alarm_ctrl;

    localparam int TH  = 4;
    localparam int BC  = 20;
    localparam int NB  = 3;
    localparam int SP  = 2;
    localparam int SES = 2 * BC * NB;
`ifdef RING_SNOOZE_EN
    localparam bit SNZ_EN = 1'b1;
`else
    localparam bit SNZ_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    ring_alarm_ctrl_if bus();

    ring_alarm_ctrl #(
        .TONE_HALF      (TH),
        .BEEP_CYC       (BC),
        .BEEPS          (NB),
        .SNOOZE_PERIODS (SP)
    ) dut (
        .CLK_NX (clk),
        .reset  (reset),
        .bus    (bus)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [2:0] v;
        int         n;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   n_step = 0;

    // Model state: offset into the running session, cycles spent snoozing, and a pending done cycle.
    int m_n = -1;
    int m_snz = -1;
    bit m_done = 1'b0;

    task automatic step(input bit a, input bit h, input bit s, input bit z, input bit r);
        bit ring, tone;
        int p;
        bus.armed     = a;
        bus.alarm_hit = h;
        bus.stop      = s;
        reset         = r;
`ifdef RING_SNOOZE_EN
        bus.snooze    = z;
`endif
        if (r) begin
            m_n = -1;
            m_snz = -1;
            m_done = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_n >= 0) begin
            if (s || !a) m_n = -1;
            else if (z && SNZ_EN) begin
                m_n = -1;
                m_snz = 0;
            end else begin
                m_n++;
                if (m_n == SES) begin
                    m_n = -1;
                    m_done = 1'b1;
                end
            end
        end else if (m_snz >= 0) begin
            if (s || !a) m_snz = -1;
            else begin
                m_snz++;
                if (m_snz == SP * 2 * BC) begin
                    m_snz = -1;
                    m_n = 0;
                end
            end
        end else if (h && a && !s) begin
            m_n = 0;
        end
        ring = m_n >= 0;
        p    = ring ? m_n % (2 * BC) : 0;
        tone = ring && p < BC && (p / TH) % 2 == 0;
        exp_q.push_back('{v: {tone, ring, m_done}, n: n_step});
        n_step++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input bit a);
        repeat (n) step(a, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [2:0] got;
            e   = exp_q.pop_front();
            got = {bus.clk_RING, bus.ringing, bus.done};
            tests++;
            if (got !== e.v) begin
                fails++;
                $display("FAIL outputs step %0d: {clk_RING,ringing,done} got %b required %b", e.n, got, e.v);
            end
        end
    end

    initial begin
        reset         = 1'b1;
        bus.armed     = 1'b0;
        bus.alarm_hit = 1'b0;
        bus.stop      = 1'b0;
`ifdef RING_SNOOZE_EN
        bus.snooze    = 1'b0;
`endif
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        run(3, 1);
        // full session
        step(1, 1, 0, 0, 0);
        run(SES + 5, 1);
        // stop in the seventh TONE_ON cycle
        step(1, 1, 0, 0, 0);
        run(6, 1);
        step(1, 0, 1, 0, 0);
        run(SES + 5, 1);
        // disarmed request, then request colliding with stop
        run(2, 0);
        step(0, 1, 0, 0, 0);
        run(5, 0);
        run(2, 1);
        step(1, 1, 1, 0, 0);
        run(5, 1);
        // disarm during TONE_OFF
        step(1, 1, 0, 0, 0);
        run(BC + 4, 1);
        step(0, 0, 0, 0, 0);
        run(4, 1);
        // retrigger during session, hit in DONE ignored, hit right after accepted
        step(1, 1, 0, 0, 0);
        for (int i = 1; i <= SES; i++) step(1, i % 37 == 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        run(SES + 5, 1);
        // reset mid-session
        step(1, 1, 0, 0, 0);
        run(49, 1);
        step(1, 0, 0, 0, 1);
        run(2, 1);
        step(1, 1, 0, 0, 0);
        run(SES + 5, 1);
`ifdef RING_SNOOZE_EN
        step(1, 1, 0, 0, 0);
        run(29, 1);
        step(1, 0, 0, 1, 0);
        run(SP * 2 * BC + SES + 5, 1);
        step(1, 1, 0, 0, 0);
        run(10, 1);
        step(1, 0, 0, 1, 0);
        run(10, 1);
        step(1, 0, 1, 0, 0);
        run(SP * 2 * BC + 10, 1);
        step(1, 1, 0, 0, 0);
        run(5, 1);
        step(1, 0, 1, 1, 0);
        run(5, 1);
`endif
        repeat (4000)
            step($urandom_range(0, 399) != 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 299) == 0, $urandom_range(0, 99) == 0,
                 $urandom_range(0, 599) == 0);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
